// File: rtl/uart_rx_adc_frontend_pkg.sv
// ============================================================================
// Module   : uart_rx_adc_frontend_pkg
// Brief    : Shared state encodings, command bytes and parameter reset values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_adc_frontend_pkg;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [0:0] DEC_CMD   = 1'b0;
  localparam logic [0:0] DEC_VALUE = 1'b1;

  localparam logic [7:0] CMD_ATTACK  = 8'h61;
  localparam logic [7:0] CMD_DECAY   = 8'h64;
  localparam logic [7:0] CMD_SUSTAIN = 8'h73;
  localparam logic [7:0] CMD_RELAX   = 8'h72;

  localparam logic [7:0] RST_ATTACK  = 8'h10;
  localparam logic [7:0] RST_DECAY   = 8'h10;
  localparam logic [7:0] RST_SUSTAIN = 8'h80;
  localparam logic [7:0] RST_RELAX   = 8'h10;

  typedef enum logic [1:0] {
    SEL_ATTACK  = 2'd0,
    SEL_DECAY   = 2'd1,
    SEL_SUSTAIN = 2'd2,
    SEL_RELAX   = 2'd3
  } param_sel_t;

  typedef struct packed {
    logic       hit;
    param_sel_t sel;
  } cmd_hit_t;

  function automatic cmd_hit_t decode_cmd(input logic [7:0] b);
    cmd_hit_t r;
    r.hit = 1'b1;
    r.sel = SEL_ATTACK;
    case (b)
      CMD_ATTACK:  r.sel = SEL_ATTACK;
      CMD_DECAY:   r.sel = SEL_DECAY;
      CMD_SUSTAIN: r.sel = SEL_SUSTAIN;
      CMD_RELAX:   r.sel = SEL_RELAX;
      default:     r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_adc_frontend_uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with input synchronizer; optional break detect
//            selected by UART_RX_BREAK_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_rx_adc_frontend_pkg::*;
#(
  parameter int CLK_HZ       = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rxd_i,
  input  logic                    uart_rx_en_i,
  output logic                    uart_rx_valid_o,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data_o,
  output logic                    uart_rx_break_o
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam int BIT_W          = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAYLOAD_BITS - 1);

  logic                    sync1_q, sync2_q;
  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    brk_q, brk_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    brk_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!sync2_q && uart_rx_en_i) begin
          state_d = RX_START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[PAYLOAD_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
          // Low stop bit: all-zero payload is a break, anything else is dropped.
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else if (shift_q == '0) begin
            brk_d = 1'b1;
          end
`else
          valid_d = 1'b1;
          data_d  = shift_q;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      sync1_q <= uart_rxd_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      brk_q   <= brk_d;
    end
  end

  assign uart_rx_valid_o = valid_q;
  assign uart_rx_data_o  = data_q;
  assign uart_rx_break_o = brk_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_adc_frontend.sv
// ============================================================================
// Module   : uart_rx_adc_frontend
// Brief    : UART receiver plus two-byte command decoder for the ADSR
//            parameter registers. Macro: UART_RX_BREAK_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_adc_frontend
  import uart_rx_adc_frontend_pkg::*;
#(
  parameter int CLK_HZ       = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_break,
  output logic [7:0]              attack,
  output logic [7:0]              decay,
  output logic [7:0]              sustain,
  output logic [7:0]              relax
);

  uart_rx #(
    .CLK_HZ       (CLK_HZ),
    .BIT_RATE     (BIT_RATE),
    .PAYLOAD_BITS (PAYLOAD_BITS)
  ) u_rx (
    .clk             (clk),
    .rst_n           (rst_n),
    .uart_rxd_i      (uart_rxd),
    .uart_rx_en_i    (uart_rx_en),
    .uart_rx_valid_o (uart_rx_valid),
    .uart_rx_data_o  (uart_rx_data),
    .uart_rx_break_o (uart_rx_break)
  );

  logic [0:0] dec_q, dec_d;
  param_sel_t sel_q, sel_d;
  logic [7:0] attack_q, attack_d, decay_q, decay_d;
  logic [7:0] sustain_q, sustain_d, relax_q, relax_d;
  cmd_hit_t   hit;

  always_comb begin
    dec_d     = dec_q;
    sel_d     = sel_q;
    attack_d  = attack_q;
    decay_d   = decay_q;
    sustain_d = sustain_q;
    relax_d   = relax_q;
    hit       = decode_cmd(uart_rx_data[7:0]);
    if (uart_rx_break) begin
      dec_d = DEC_CMD;
    end else if (uart_rx_valid) begin
      if (dec_q == DEC_CMD) begin
        if (hit.hit) begin
          sel_d = hit.sel;
          dec_d = DEC_VALUE;
        end
      end else begin
        // Value byte is taken verbatim, even if it looks like a command letter.
        dec_d = DEC_CMD;
        case (sel_q)
          SEL_ATTACK:  attack_d  = uart_rx_data[7:0];
          SEL_DECAY:   decay_d   = uart_rx_data[7:0];
          SEL_SUSTAIN: sustain_d = uart_rx_data[7:0];
          SEL_RELAX:   relax_d   = uart_rx_data[7:0];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q     <= DEC_CMD;
      sel_q     <= SEL_ATTACK;
      attack_q  <= RST_ATTACK;
      decay_q   <= RST_DECAY;
      sustain_q <= RST_SUSTAIN;
      relax_q   <= RST_RELAX;
    end else begin
      dec_q     <= dec_d;
      sel_q     <= sel_d;
      attack_q  <= attack_d;
      decay_q   <= decay_d;
      sustain_q <= sustain_d;
      relax_q   <= relax_d;
    end
  end

  assign attack  = attack_q;
  assign decay   = decay_q;
  assign sustain = sustain_q;
  assign relax   = relax_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_adc_frontend.sv
// ============================================================================
// Module   : tb_uart_rx_adc_frontend
// Brief    : Randomized self-checking bench for uart_rx_adc_frontend.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_adc_frontend;

  localparam int CLK_HZ   = 3200000;
  localparam int BIT_RATE = 100000;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int HALF     = CPB / 2;
  localparam int LAT      = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_en = 1'b1;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_break;
  logic [7:0] attack, decay, sustain, relax;

  uart_rx_adc_frontend #(
    .CLK_HZ       (CLK_HZ),
    .BIT_RATE     (BIT_RATE),
    .PAYLOAD_BITS (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rxd      (uart_rxd),
    .uart_rx_en    (uart_rx_en),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_break (uart_rx_break),
    .attack        (attack),
    .decay         (decay),
    .sustain       (sustain),
    .relax         (relax)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- strobe monitor ----------------
  typedef struct packed {
    logic        is_brk;
    logic [7:0]  data;
    logic [31:0] at;
  } ev_t;

  ev_t        evq[$];
  logic       prev_valid = 1'b0;
  logic       post_pend  = 1'b0;
  logic [7:0] pre_attack = 8'h00;
  logic [7:0] post_attack = 8'h00;

  always @(negedge clk) begin
    if (uart_rx_valid || uart_rx_break)
      chk("strobe_excl", 32'(uart_rx_valid & uart_rx_break), 32'd0);
    if (uart_rx_valid)
      chk("valid_width", 32'(prev_valid), 32'd0);
    if (uart_rx_valid) evq.push_back('{1'b0, uart_rx_data, 32'(cyc)});
    if (uart_rx_break) evq.push_back('{1'b1, 8'h00, 32'(cyc)});
    if (uart_rx_valid) pre_attack <= attack;
    if (post_pend) post_attack <= attack;
    post_pend  <= uart_rx_valid;
    prev_valid <= uart_rx_valid;
  end

  // ---------------- reference model ----------------
  logic [7:0] m_reg[4];
  logic       m_value;
  int         m_sel;
  logic [7:0] m_data;

  function automatic void model_reset();
    m_reg[0] = 8'h10; m_reg[1] = 8'h10; m_reg[2] = 8'h80; m_reg[3] = 8'h10;
    m_value  = 1'b0;
    m_sel    = 0;
    m_data   = 8'h00;
  endfunction

  function automatic int cmd_index(input logic [7:0] b);
    if (b == "a") return 0;
    if (b == "d") return 1;
    if (b == "s") return 2;
    if (b == "r") return 3;
    return -1;
  endfunction

  function automatic logic [7:0] cmd_char(input int i);
    case (i)
      0:       return "a";
      1:       return "d";
      2:       return "s";
      default: return "r";
    endcase
  endfunction

  // Returns 0 = no strobe, 1 = valid byte, 2 = break; updates model state.
  function automatic int model_frame(input logic [7:0] b, input logic stop);
    int kind;
`ifdef UART_RX_BREAK_DETECT_EN
    kind = stop ? 1 : ((b == 8'h00) ? 2 : 0);
`else
    kind = 1;
`endif
    if (kind == 1) begin
      m_data = b;
      if (m_value) begin
        m_reg[m_sel] = b;
        m_value = 1'b0;
      end else if (cmd_index(b) >= 0) begin
        m_sel   = cmd_index(b);
        m_value = 1'b1;
      end
    end else if (kind == 2) begin
      m_value = 1'b0;
    end
    return kind;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".attack"},  32'(attack),       32'(m_reg[0]));
    chk({tag, ".decay"},   32'(decay),        32'(m_reg[1]));
    chk({tag, ".sustain"}, 32'(sustain),      32'(m_reg[2]));
    chk({tag, ".relax"},   32'(relax),        32'(m_reg[3]));
    chk({tag, ".data"},    32'(uart_rx_data), 32'(m_data));
  endtask

  // ---------------- stimulus ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    @(negedge clk);
    uart_rxd = 1'b0;
    t0 = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input logic stop,
                          input int gap, input logic drop_en);
    int   t0, kind, d;
    ev_t  ev;
    kind = model_frame(b, stop);
    fork
      send_frame(b, stop, t0);
      begin
        if (drop_en) begin
          repeat (3 * CPB) @(negedge clk);
          uart_rx_en = 1'b0;
        end
      end
    join
    // a low stop bit needs recovery time on the line before another start
    repeat (stop ? gap : 2 * CPB) @(negedge clk);
    uart_rx_en = 1'b1;
    if (kind == 0) begin
      chk({tag, ".no_strobe"}, 32'(evq.size()), 32'd0);
    end else begin
      chk({tag, ".strobes"}, 32'(evq.size()), 32'd1);
      if (evq.size() > 0) begin
        ev = evq.pop_front();
        chk({tag, ".is_break"}, 32'(ev.is_brk), 32'(kind == 2));
        if (kind == 1) begin
          chk({tag, ".byte"}, 32'(ev.data), 32'(b));
          d = int'(ev.at) - t0;
          chk({tag, ".latency_ok"}, 32'(d >= LAT - 1 && d <= LAT + 1), 32'd1);
        end
      end
    end
    evq.delete();
    check_regs(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    int         t0;

    model_reset();
    repeat (5) @(negedge clk);
    chk("rst.valid", 32'(uart_rx_valid), 32'd0);
    chk("rst.break", 32'(uart_rx_break), 32'd0);
    check_regs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    do_frame("single55", 8'h55, 1'b1, CPB, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    chk("single55.held", 32'(uart_rx_data), 32'h55);

    do_frame("wr_a_cmd", "a", 1'b1, 0, 1'b0);
    do_frame("wr_a_val", 8'h40, 1'b1, 5, 1'b0);
    chk("wr_a.before", 32'(pre_attack), 32'h10);
    chk("wr_a.after1", 32'(post_attack), 32'h40);
    do_frame("wr_s_cmd", "s", 1'b1, 3, 1'b0);
    do_frame("wr_s_val", "s", 1'b1, 3, 1'b0);

    do_frame("ign_x", "x", 1'b1, 3, 1'b0);
    do_frame("ign_40", 8'h40, 1'b1, 3, 1'b0);

    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (HALF - 4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch.no_strobe", 32'(evq.size()), 32'd0);
    evq.delete();
    do_frame("after_glitch", 8'hC3, 1'b1, 2, 1'b0);

    uart_rx_en = 1'b0;
    send_frame(8'h5A, 1'b1, t0);
    repeat (CPB) @(negedge clk);
    chk("en_low.no_strobe", 32'(evq.size()), 32'd0);
    evq.delete();
    uart_rx_en = 1'b1;
    do_frame("en_drop", 8'h3C, 1'b1, 4, 1'b1);

    do_frame("brk", 8'h00, 1'b0, 0, 1'b0);
    do_frame("brk_d", "d", 1'b1, 2, 1'b0);
    do_frame("brk_d_brk", 8'h00, 1'b0, 0, 1'b0);
    do_frame("brk_next", "r", 1'b1, 2, 1'b0);
    do_frame("brk_val", 8'h99, 1'b1, 2, 1'b0);
    do_frame("ferr", 8'hA7, 1'b0, 0, 1'b0);

    for (int k = 0; k < 45; k++) begin
      b = ($urandom_range(0, 7) < 4) ? cmd_char($urandom_range(0, 3)) : 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      if (!stop && $urandom_range(0, 1) == 1) b = 8'h00;
      do_frame("rand", b, stop, $urandom_range(0, 40), 1'($urandom_range(0, 7) == 0));
    end

    fork
      send_frame(8'hA5, 1'b1, t0);
      begin
        repeat (5 * CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("async_rst");
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("midrst.no_strobe", 32'(evq.size()), 32'd0);
    evq.delete();
    do_frame("post_rst_cmd", "d", 1'b1, 2, 1'b0);
    do_frame("post_rst_val", 8'h22, 1'b1, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
